// File: rtl/proxy_response_return.sv
// rtl/proxy_response_return.sv - tags outstanding requests and routes responses back only to their owner

module proxy_response_return #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 2,
    parameter int SRC_W = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc_valid,
    input  logic [SRC_W-1:0] alloc_src_id,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             rsp_in_valid,
    output logic             rsp_in_ready,
    input  logic [TAG_W-1:0] rsp_in_tag,
    input  logic [WIDTH-1:0] rsp_in_data,
    output logic             rsp_out_valid,
    input  logic             rsp_out_ready,
    output logic [WIDTH-1:0] rsp_out_data,
    output logic [SRC_W-1:0] rsp_out_dst_id,
    output logic             err_unsolicited,
    output logic [ERR_W-1:0] err_count,
    output logic [TAG_W:0]   outstanding
);

    localparam int DEPTH = 1 << TAG_W;

    logic [DEPTH-1:0] entry_valid;
    logic [SRC_W-1:0] entry_src [DEPTH];

    logic alloc_fire;
    logic rsp_accept;
    logic rsp_auth;
    logic rsp_unsol;

    // Lowest free tag wins; scanning downward lets the last hit be the lowest index.
    always_comb begin
        alloc_ready = 1'b0;
        alloc_tag   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entry_valid[i]) begin
                alloc_ready = 1'b1;
                alloc_tag   = TAG_W'(i);
            end
        end
    end

    assign rsp_in_ready = !rsp_out_valid || rsp_out_ready;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign rsp_accept   = rsp_in_valid && rsp_in_ready;
    assign rsp_auth     = rsp_accept && entry_valid[rsp_in_tag];
    assign rsp_unsol    = rsp_accept && !entry_valid[rsp_in_tag];

    // The granted tag is always a free entry and the freed tag always a valid
    // one, so both updates can land on the same edge without colliding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_src[i] <= '0;
            end
        end else begin
            if (alloc_fire) begin
                entry_valid[alloc_tag] <= 1'b1;
                entry_src[alloc_tag]   <= alloc_src_id;
            end
            if (rsp_auth) begin
                entry_valid[rsp_in_tag] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({alloc_fire, rsp_auth})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Single output register; unsolicited payloads never reach rsp_out_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_out_valid  <= 1'b0;
            rsp_out_data   <= '0;
            rsp_out_dst_id <= '0;
        end else if (rsp_auth) begin
            rsp_out_valid  <= 1'b1;
            rsp_out_data   <= rsp_in_data;
            rsp_out_dst_id <= entry_src[rsp_in_tag];
        end else if (rsp_out_ready) begin
            rsp_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_unsolicited <= 1'b0;
            err_count       <= '0;
        end else begin
            err_unsolicited <= rsp_unsol;
            if (rsp_unsol && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proxy_response_return.sv
// tb/tb_proxy_response_return.sv - directed self-checking bench for proxy_response_return

module tb_proxy_response_return;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alloc_valid;
    logic [3:0]  alloc_src_id;
    logic        alloc_ready;
    logic [1:0]  alloc_tag;
    logic        rsp_in_valid;
    logic        rsp_in_ready;
    logic [1:0]  rsp_in_tag;
    logic [31:0] rsp_in_data;
    logic        rsp_out_valid;
    logic        rsp_out_ready;
    logic [31:0] rsp_out_data;
    logic [3:0]  rsp_out_dst_id;
    logic        err_unsolicited;
    logic [7:0]  err_count;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;

    proxy_response_return #(.WIDTH(32), .TAG_W(2), .SRC_W(4), .ERR_W(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .alloc_valid     (alloc_valid),
        .alloc_src_id    (alloc_src_id),
        .alloc_ready     (alloc_ready),
        .alloc_tag       (alloc_tag),
        .rsp_in_valid    (rsp_in_valid),
        .rsp_in_ready    (rsp_in_ready),
        .rsp_in_tag      (rsp_in_tag),
        .rsp_in_data     (rsp_in_data),
        .rsp_out_valid   (rsp_out_valid),
        .rsp_out_ready   (rsp_out_ready),
        .rsp_out_data    (rsp_out_data),
        .rsp_out_dst_id  (rsp_out_dst_id),
        .err_unsolicited (err_unsolicited),
        .err_count       (err_count),
        .outstanding     (outstanding)
    );

    always #5 clk = ~clk;

    // Inputs change 1 unit after the rising edge; outputs are sampled 2 units after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        alloc_valid   = 1'b0;
        alloc_src_id  = '0;
        rsp_in_valid  = 1'b0;
        rsp_in_tag    = '0;
        rsp_in_data   = '0;
        rsp_out_ready = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        settle();
        checks++; if (rsp_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", rsp_out_valid); end
        checks++; if (rsp_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", rsp_out_data); end
        checks++; if (rsp_out_dst_id !== 4'h0) begin errors++; $display("FAIL reset_dst_id: got %h want 0", rsp_out_dst_id); end
        checks++; if (err_unsolicited !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b want 0", err_unsolicited); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 2'd0) begin errors++; $display("FAIL reset_alloc: got ready=%b tag=%0d want ready=1 tag=0", alloc_ready, alloc_tag); end
        checks++; if (rsp_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", rsp_in_ready); end
        tick();
    endtask

    task automatic test_basic_route();
        alloc_valid  = 1'b1;
        alloc_src_id = 4'd3;
        settle();
        checks++; if (alloc_tag !== 2'd0) begin errors++; $display("FAIL basic_alloc_tag: got %0d want 0", alloc_tag); end
        tick();
        alloc_valid = 1'b0;
        settle();
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL basic_outstanding_1: got %0d want 1", outstanding); end
        rsp_in_valid = 1'b1;
        rsp_in_tag   = 2'd0;
        rsp_in_data  = 32'hDEADBEEF;
        tick();
        rsp_in_valid = 1'b0;
        settle();
        checks++; if (rsp_out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", rsp_out_valid); end
        checks++; if (rsp_out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_out_data: got %h want deadbeef", rsp_out_data); end
        checks++; if (rsp_out_dst_id !== 4'd3) begin errors++; $display("FAIL basic_dst_id: got %0d want 3", rsp_out_dst_id); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL basic_outstanding_0: got %0d want 0", outstanding); end
        tick();
        checks++; if (rsp_out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_clear: got %b want 0", rsp_out_valid); end
    endtask

    task automatic test_full_table();
        logic [1:0] exp_tag;
        for (int i = 0; i < 4; i++) begin
            alloc_valid  = 1'b1;
            alloc_src_id = 4'(i + 1);
            exp_tag      = 2'(i);
            settle();
            checks++; if (alloc_tag !== exp_tag) begin errors++; $display("FAIL full_alloc_tag_%0d: got %0d want %0d", i, alloc_tag, exp_tag); end
            tick();
        end
        alloc_src_id = 4'd9;
        settle();
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready: got %b want 0", alloc_ready); end
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding_4: got %0d want 4", outstanding); end
        tick();
        alloc_valid = 1'b0;
        settle();
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_fifth_not_granted: got %0d want 4", outstanding); end
        rsp_in_valid = 1'b1;
        rsp_in_tag   = 2'd2;
        rsp_in_data  = 32'h000000A5;
        tick();
        rsp_in_valid = 1'b0;
        settle();
        checks++; if (rsp_out_dst_id !== 4'd3 || rsp_out_data !== 32'hA5) begin errors++; $display("FAIL full_tag2_route: got dst=%0d data=%h want dst=3 data=a5", rsp_out_dst_id, rsp_out_data); end
        checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 2'd2) begin errors++; $display("FAIL full_regrant: got ready=%b tag=%0d want ready=1 tag=2", alloc_ready, alloc_tag); end
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_outstanding_3: got %0d want 3", outstanding); end
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
                rsp_in_valid = 1'b1;
                rsp_in_tag   = 2'(i);
                rsp_in_data  = 32'(i);
                tick();
            end
        end
        rsp_in_valid = 1'b0;
        tick();
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", outstanding); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL full_no_errors: got %0d want 0", err_count); end
    endtask

    task automatic test_unsolicited();
        rsp_in_valid = 1'b1;
        rsp_in_tag   = 2'd1;
        rsp_in_data  = 32'h12345678;
        tick();
        rsp_in_valid = 1'b0;
        settle();
        checks++; if (rsp_out_valid !== 1'b0) begin errors++; $display("FAIL unsol_not_forwarded: got %b want 0", rsp_out_valid); end
        checks++; if (rsp_out_data === 32'h12345678) begin errors++; $display("FAIL unsol_data_leak: got %h want anything else", rsp_out_data); end
        checks++; if (err_unsolicited !== 1'b1) begin errors++; $display("FAIL unsol_pulse: got %b want 1", err_unsolicited); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL unsol_count: got %0d want 1", err_count); end
        tick();
        checks++; if (err_unsolicited !== 1'b0) begin errors++; $display("FAIL unsol_pulse_end: got %b want 0", err_unsolicited); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL unsol_count_hold: got %0d want 1", err_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            alloc_valid  = 1'b1;
            alloc_src_id = 4'(i + 5);
            tick();
        end
        alloc_valid   = 1'b0;
        rsp_out_ready = 1'b0;
        rsp_in_valid  = 1'b1;
        rsp_in_tag    = 2'd0;
        rsp_in_data   = 32'd100;
        tick();
        rsp_in_tag  = 2'd1;
        rsp_in_data = 32'd101;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (rsp_out_valid !== 1'b1 || rsp_out_data !== 32'd100 || rsp_out_dst_id !== 4'd5) begin errors++; $display("FAIL stall_hold_%0d: got v=%b data=%0d dst=%0d want v=1 data=100 dst=5", i, rsp_out_valid, rsp_out_data, rsp_out_dst_id); end
            checks++; if (rsp_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d: got %b want 0", i, rsp_in_ready); end
            tick();
        end
        rsp_out_ready = 1'b1;
        tick();
        rsp_in_tag  = 2'd2;
        rsp_in_data = 32'd102;
        settle();
        checks++; if (rsp_out_valid !== 1'b1 || rsp_out_data !== 32'd101 || rsp_out_dst_id !== 4'd6) begin errors++; $display("FAIL b2b_second: got v=%b data=%0d dst=%0d want v=1 data=101 dst=6", rsp_out_valid, rsp_out_data, rsp_out_dst_id); end
        tick();
        rsp_in_valid = 1'b0;
        settle();
        checks++; if (rsp_out_valid !== 1'b1 || rsp_out_data !== 32'd102 || rsp_out_dst_id !== 4'd7) begin errors++; $display("FAIL b2b_third: got v=%b data=%0d dst=%0d want v=1 data=102 dst=7", rsp_out_valid, rsp_out_data, rsp_out_dst_id); end
        tick();
        checks++; if (rsp_out_valid !== 1'b0 || outstanding !== 3'd0) begin errors++; $display("FAIL b2b_drain: got v=%b outstanding=%0d want v=0 outstanding=0", rsp_out_valid, outstanding); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL b2b_no_loss: got err_count=%0d want 1", err_count); end
    endtask

    task automatic test_simultaneous();
        alloc_valid  = 1'b1;
        alloc_src_id = 4'd1;
        tick();
        alloc_src_id = 4'd2;
        tick();
        alloc_src_id = 4'd7;
        rsp_in_valid = 1'b1;
        rsp_in_tag   = 2'd0;
        rsp_in_data  = 32'h55;
        settle();
        checks++; if (alloc_tag !== 2'd2) begin errors++; $display("FAIL simul_grant: got %0d want 2", alloc_tag); end
        tick();
        alloc_valid  = 1'b0;
        rsp_in_valid = 1'b0;
        settle();
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL simul_outstanding: got %0d want 2", outstanding); end
        checks++; if (rsp_out_dst_id !== 4'd1 || rsp_out_data !== 32'h55) begin errors++; $display("FAIL simul_route: got dst=%0d data=%h want dst=1 data=55", rsp_out_dst_id, rsp_out_data); end
        checks++; if (alloc_tag !== 2'd0) begin errors++; $display("FAIL simul_tag0_free_next: got %0d want 0", alloc_tag); end
        rsp_in_valid = 1'b1;
        rsp_in_tag   = 2'd2;
        rsp_in_data  = 32'h77;
        tick();
        settle();
        checks++; if (rsp_out_dst_id !== 4'd7) begin errors++; $display("FAIL simul_tag2_owner: got %0d want 7", rsp_out_dst_id); end
        rsp_in_tag = 2'd1;
        tick();
        // Second response to tag 1 is a duplicate.
        tick();
        rsp_in_valid = 1'b0;
        settle();
        checks++; if (err_unsolicited !== 1'b1 || err_count !== 8'd2) begin errors++; $display("FAIL dup_flagged: got pulse=%b count=%0d want pulse=1 count=2", err_unsolicited, err_count); end
        checks++; if (rsp_out_valid !== 1'b0 || outstanding !== 3'd0) begin errors++; $display("FAIL dup_dropped: got v=%b outstanding=%0d want v=0 outstanding=0", rsp_out_valid, outstanding); end
        tick();
    endtask

    task automatic test_saturate_and_reset();
        alloc_valid  = 1'b1;
        alloc_src_id = 4'd4;
        tick();
        tick();
        alloc_valid  = 1'b0;
        rsp_in_valid = 1'b1;
        rsp_in_tag   = 2'd3;
        rsp_in_data  = 32'hBAD0BAD0;
        repeat (300) tick();
        settle();
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", err_count); end
        checks++; if (outstanding !== 3'd2 || rsp_out_valid !== 1'b0) begin errors++; $display("FAIL sat_no_forward: got outstanding=%0d v=%b want 2 and 0", outstanding, rsp_out_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (err_count !== 8'd0 || outstanding !== 3'd0 || rsp_out_valid !== 1'b0 || err_unsolicited !== 1'b0) begin errors++; $display("FAIL async_reset: got count=%0d outstanding=%0d v=%b pulse=%b want all 0", err_count, outstanding, rsp_out_valid, err_unsolicited); end
        rsp_in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        rsp_in_valid = 1'b1;
        rsp_in_tag   = 2'd0;
        rsp_in_data  = 32'h0000CAFE;
        tick();
        rsp_in_valid = 1'b0;
        settle();
        checks++; if (rsp_out_valid !== 1'b0 || err_count !== 8'd1) begin errors++; $display("FAIL stale_tag_after_reset: got v=%b count=%0d want v=0 count=1", rsp_out_valid, err_count); end
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_full_table();
        test_unsolicited();
        test_back_to_back();
        test_simultaneous();
        test_saturate_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
